// File: rtl/ysyx_22050133_ifu_pkg.sv
// Shared constants, state encoding and helpers for the instruction fetch unit.
package ysyx_22050133_ifu_pkg;

    localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } ifu_state_e;

    function automatic logic [63:0] word_align(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_22050133_ifu_fifo.sv
// Small synchronous FIFO with flush; head is the oldest entry, valid when count != 0.
module ysyx_22050133_ifu_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_pop  = pop & (count_reg != '0);
    assign do_push = push & ((count_reg != CW'(DEPTH)) | do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/ysyx_22050133_ifu.sv
// Instruction fetch unit: issues word fetches, tracks in-flight PCs, buffers
// returned instructions for decode and discards wrong-path responses after a redirect.
module ysyx_22050133_ifu
    import ysyx_22050133_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = IFU_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [63:0] id_pc,
    output logic [31:0] id_inst
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = CW + 1;

    ifu_state_e    state_reg;
    ifu_state_e    state_next;
    logic [63:0]   pc_reg;
    logic          pend_reg;
    logic          pend_stale_reg;
    logic [63:0]   pend_addr_reg;
    logic [CW-1:0] drop_cnt_reg;
    logic [CW-1:0] drop_cnt_next;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_count;
    logic [63:0]   pcq_head;
    logic [95:0]   ibuf_head;

    logic          req_fire;
    logic          req_stall;
    logic          rsp_take;
    logic          redirect_take;
    logic          id_fire;
    logic          push_inst;
    logic [CW-1:0] out_after;
    logic [CW-1:0] drop_redirect;
    logic [SW-1:0] credit_used;

    assign req_fire      = imem_req_valid & imem_req_ready;
    assign req_stall     = imem_req_valid & ~imem_req_ready;
    assign rsp_take      = imem_rsp_valid & (outstanding != '0);
    assign redirect_take = redirect_valid & (state_reg != S_BOOT);
    assign id_fire       = id_valid & id_ready;
    assign push_inst     = rsp_take & (state_reg == S_RUN) & ~redirect_take;
    assign out_after     = outstanding + CW'(req_fire) - CW'(rsp_take);
    assign drop_redirect = out_after + CW'(req_stall);
    // An entry leaving for decode this cycle frees its slot now, which sustains one fetch per cycle.
    assign credit_used   = {1'b0, outstanding} + {1'b0, fifo_count} - SW'(id_fire);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        drop_cnt_next = drop_cnt_reg;
        case (state_reg)
            S_BOOT:  state_next = S_RUN;
            S_RUN:   state_next = S_RUN;
            S_DRAIN: begin
                if (rsp_take) begin
                    drop_cnt_next = drop_cnt_reg - CW'(1);
                    if (drop_cnt_reg == CW'(1)) begin
                        state_next = S_RUN;
                    end
                end
            end
            default: state_next = S_BOOT;
        endcase
        if (redirect_take) begin
            drop_cnt_next = drop_redirect;
            state_next    = (drop_redirect != '0) ? S_DRAIN : S_RUN;
        end
    end

    // A request already on the bus is held until accepted, whatever the state.
    always_comb begin
        imem_req_valid = pend_reg;
        imem_req_addr  = pend_reg ? pend_addr_reg : pc_reg;
        if (state_reg == S_RUN && credit_used < SW'(FIFO_DEPTH)) begin
            imem_req_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg         <= RESET_PC;
            pend_reg       <= 1'b0;
            pend_stale_reg <= 1'b0;
            pend_addr_reg  <= RESET_PC;
            drop_cnt_reg   <= '0;
        end else begin
            drop_cnt_reg   <= drop_cnt_next;
            pend_reg       <= req_stall;
            pend_addr_reg  <= imem_req_addr;
            pend_stale_reg <= req_stall & (redirect_take | (pend_reg & pend_stale_reg));
            // A stale pending request was issued before the redirect, so it must not advance the new PC.
            if (redirect_take) begin
                pc_reg <= word_align(redirect_pc);
            end else if (req_fire && !(pend_reg && pend_stale_reg)) begin
                pc_reg <= pc_reg + 64'd4;
            end
        end
    end

    ysyx_22050133_ifu_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(64)
    ) u_pcq (
        .clk      (clk),
        .rst      (rst),
        .flush    (1'b0),
        .push     (req_fire),
        .push_data(imem_req_addr),
        .pop      (rsp_take),
        .head     (pcq_head),
        .count    (outstanding)
    );

    ysyx_22050133_ifu_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(96)
    ) u_ibuf (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_take),
        .push     (push_inst),
        .push_data({pcq_head, imem_rsp_data}),
        .pop      (id_fire),
        .head     (ibuf_head),
        .count    (fifo_count)
    );

    assign id_valid = (fifo_count != '0);
    assign id_pc    = id_valid ? ibuf_head[95:32] : 64'd0;
    assign id_inst  = id_valid ? ibuf_head[31:0] : INST_NOP;

    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_ysyx_22050133_ifu.sv
// Directed bench for the fetch unit: a queued memory model with adjustable hold,
// in-order delivery checking and hand-derived checkpoints around redirects and reset.
module tb_ysyx_22050133_ifu;
    import ysyx_22050133_ifu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [31:0] id_inst;

    ysyx_22050133_ifu dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_pc         (id_pc),
        .id_inst       (id_inst)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          n_deliv = 0;
    int          d0;
    bit          k_rst = 1'b0;
    bit          k_mem_ready = 1'b1;
    bit          k_id_ready = 1'b1;
    bit          mem_hold = 1'b0;
    int          lat = 1;
    logic [63:0] exp_pc = 64'h8000_0000;
    logic [63:0] mq_addr[$];
    int          mq_due[$];

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] + 32'h1000_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive at the falling edge, observe 2 units later, well before the rising edge.
    task automatic cycle(input bit redir = 1'b0, input logic [63:0] tgt = 64'd0);
        @(negedge clk);
        rst            = k_rst;
        imem_req_ready = k_mem_ready;
        id_ready       = k_id_ready;
        redirect_valid = redir;
        redirect_pc    = tgt;
        if (!mem_hold && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'd0;
        end
        #2;
        if (imem_req_valid && imem_req_ready) begin
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + lat);
        end
        if (id_valid && id_ready) begin
            check("id_pc", id_pc, exp_pc);
            check("id_inst", {32'd0, id_inst}, {32'd0, inst_of(exp_pc)});
            exp_pc = exp_pc + 64'd4;
            n_deliv++;
        end
        if (redir) begin
            exp_pc = {tgt[63:2], 2'b00};
        end
        $display("cyc %0d rst=%0b req=%0b/%0b addr=%h rsp=%0b redir=%0b id=%0b/%0b pc=%h inst=%h",
                 cyc, rst, imem_req_valid, imem_req_ready, imem_req_addr, imem_rsp_valid,
                 redirect_valid, id_valid, id_ready, id_pc, id_inst);
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, {63'd0, imem_req_valid}, 64'd0);
        check({tag, "_req_addr"}, imem_req_addr, 64'h8000_0000);
        check({tag, "_id_valid"}, {63'd0, id_valid}, 64'd0);
        check({tag, "_id_pc"}, id_pc, 64'd0);
        check({tag, "_id_inst"}, {32'd0, id_inst}, 64'h13);
    endtask

    initial begin
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        id_ready       = 1'b1;

        // Reset state and first fetches.
        repeat (2) cycle();
        check_reset_outputs("reset");
        k_rst = 1'b1;
        cycle();
        check("boot_state", 64'(dut.state_reg), 64'(S_BOOT));
        check("boot_req_valid", {63'd0, imem_req_valid}, 64'd0);
        cycle();
        check("first_req_valid", {63'd0, imem_req_valid}, 64'd1);
        check("first_req_addr", imem_req_addr, 64'h8000_0000);
        cycle();
        check("second_req_addr", imem_req_addr, 64'h8000_0004);
        check("early_id_valid", {63'd0, id_valid}, 64'd0);
        check("early_id_inst", {32'd0, id_inst}, 64'h13);
        cycle();
        check("first_id_valid", {63'd0, id_valid}, 64'd1);
        d0 = n_deliv;
        repeat (8) cycle();
        check("steady_rate", 64'(n_deliv - d0), 64'd8);

        // Decode stall for 10 cycles, then resume in order.
        k_id_ready = 1'b0;
        repeat (10) cycle();
        check("stall_fifo_count", 64'(dut.fifo_count), 64'd2);
        check("stall_outstanding", 64'(dut.outstanding), 64'd0);
        check("stall_req_valid", {63'd0, imem_req_valid}, 64'd0);
        check("stall_id_valid", {63'd0, id_valid}, 64'd1);
        k_id_ready = 1'b1;
        d0 = n_deliv;
        repeat (6) cycle();
        check("resume_rate", 64'(n_deliv - d0), 64'd6);

        // Redirect with two requests outstanding.
        mem_hold = 1'b1;
        repeat (4) cycle();
        check("hold_outstanding", 64'(dut.outstanding), 64'd2);
        check("hold_id_valid", {63'd0, id_valid}, 64'd0);
        cycle(1'b1, 64'h8000_0103);
        cycle();
        check("drain_state", 64'(dut.state_reg), 64'(S_DRAIN));
        check("drain_drop_cnt", 64'(dut.drop_cnt_reg), 64'd2);
        check("drain_req_valid", {63'd0, imem_req_valid}, 64'd0);
        check("drain_id_inst", {32'd0, id_inst}, 64'h13);
        mem_hold = 1'b0;
        d0 = n_deliv;
        repeat (2) cycle();
        cycle();
        check("redir_req_valid", {63'd0, imem_req_valid}, 64'd1);
        check("redir_req_addr", imem_req_addr, 64'h8000_0100);
        check("drain_no_deliv", 64'(n_deliv - d0), 64'd0);
        cycle();
        check("redir_wait_id_valid", {63'd0, id_valid}, 64'd0);
        cycle();
        check("redir_first_deliv", 64'(n_deliv - d0), 64'd1);
        repeat (3) cycle();

        // Memory not ready while a redirect pulses: the pending request is held.
        k_mem_ready = 1'b0;
        cycle();
        check("pend_valid", {63'd0, imem_req_valid}, 64'd1);
        check("pend_addr0", imem_req_addr, 64'h8000_0118);
        cycle(1'b1, 64'h8000_0200);
        check("pend_addr1", imem_req_addr, 64'h8000_0118);
        cycle();
        check("pend_addr2", imem_req_addr, 64'h8000_0118);
        check("pend_state", 64'(dut.state_reg), 64'(S_DRAIN));
        check("pend_drop_cnt", 64'(dut.drop_cnt_reg), 64'd1);
        check("pend_id_valid", {63'd0, id_valid}, 64'd0);
        k_mem_ready = 1'b1;
        cycle();
        check("pend_addr3", imem_req_addr, 64'h8000_0118);
        cycle();
        check("pend_drop_req_valid", {63'd0, imem_req_valid}, 64'd0);
        cycle();
        check("pend_next_valid", {63'd0, imem_req_valid}, 64'd1);
        check("pend_next_addr", imem_req_addr, 64'h8000_0200);
        repeat (4) cycle();

        // Redirect coinciding with a response and an id fire.
        cycle(1'b1, 64'h8000_0300);
        d0 = n_deliv;
        cycle();
        check("coinc_state", 64'(dut.state_reg), 64'(S_DRAIN));
        check("coinc_drop_cnt", 64'(dut.drop_cnt_reg), 64'd1);
        check("coinc_fifo_count", 64'(dut.fifo_count), 64'd0);
        check("coinc_id_valid", {63'd0, id_valid}, 64'd0);
        cycle();
        check("coinc_req_addr", imem_req_addr, 64'h8000_0300);
        cycle();
        check("coinc_wait_id_valid", {63'd0, id_valid}, 64'd0);
        cycle();
        check("coinc_deliv", 64'(n_deliv - d0), 64'd1);

        // Asynchronous reset in the middle of a drain.
        mem_hold = 1'b1;
        repeat (4) cycle();
        check("hold2_outstanding", 64'(dut.outstanding), 64'd2);
        cycle(1'b1, 64'h8000_0400);
        cycle();
        check("drain2_state", 64'(dut.state_reg), 64'(S_DRAIN));
        #1;
        k_rst = 1'b0;
        rst   = 1'b0;
        #1;
        check_reset_outputs("async");
        check("async_state", 64'(dut.state_reg), 64'(S_BOOT));
        mq_addr.delete();
        mq_due.delete();
        mem_hold = 1'b0;
        exp_pc   = 64'h8000_0000;
        cycle();
        k_rst = 1'b1;
        cycle();
        check("rst2_boot_req_valid", {63'd0, imem_req_valid}, 64'd0);
        cycle();
        check("rst2_req_valid", {63'd0, imem_req_valid}, 64'd1);
        check("rst2_req_addr", imem_req_addr, 64'h8000_0000);
        d0 = n_deliv;
        repeat (3) cycle();
        check("rst2_deliv", 64'(n_deliv - d0), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22050133_ifu.md
Name: ysyx_22050133_ifu

Overview:
- Instruction fetch unit: the producer end of the decode interface. It generates PCs, issues word fetches to the instruction memory port, and buffers the returned instructions.
- It delivers {pc, inst} pairs to the decode stage over a valid/ready handshake.
- A decode-side stall (load-use hazard or any downstream back-pressure) arrives as deasserted id_ready.
- Control-flow changes resolved later in the pipeline (branch, jal/jalr, ecall, mret) arrive on the redirect port and flush wrong-path fetches.

Parameters:
- RESET_PC, 64'h8000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2). Also the fetch credit limit.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  64  fetch address, word aligned.
- imem_rsp_valid  input  1  response valid. Responses are in order, with no back-pressure.
- imem_rsp_data  input  32  fetched instruction.
- redirect_valid  input  1  pipeline redirect, one-cycle pulse.
- redirect_pc  input  64  redirect target; bits [1:0] are ignored.
- id_valid  output  1  instruction available to decode.
- id_ready  input  1  decode accepts (low while the decode stage reports a hazard or is stalled).
- id_pc  output  64  PC of the delivered instruction.
- id_inst  output  32  delivered instruction. Equals NOP (32'h00000013) whenever id_valid=0.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - pc=RESET_PC, state=S_BOOT, outstanding=0, drop_cnt=0, FIFO empty.
  - imem_req_valid=0, imem_req_addr=RESET_PC.
  - id_valid=0, id_pc=0, id_inst=NOP.
- Reset asserted mid-operation discards all buffered and in-flight state. Responses arriving after reset release to memory's outstanding requests are the memory's responsibility (memory is reset together).
- FSM states:
  - S_BOOT: one cycle after reset release; no request; goes to S_RUN.
  - S_RUN: issues fetches.
  - S_DRAIN: discards stale responses. No new request is issued. Goes to S_RUN in the cycle drop_cnt reaches 0.
- Issue rule (S_RUN):
  - imem_req_valid=1 when outstanding + fifo_count < FIFO_DEPTH, or when a request is already pending.
  - imem_req_addr=pc.
  - On req fire: pc <= pc+4, outstanding++.
- Request stability: once imem_req_valid=1, both valid and addr stay stable until imem_req_ready, including across a redirect.
- Response in S_RUN: push {issued pc, rsp_data} into the FIFO; outstanding--. Each issued address is held in a FIFO_DEPTH-entry in-order PC queue alongside outstanding.
- Response in S_DRAIN: discarded; drop_cnt--, outstanding--.
- A response with outstanding==0 is a protocol violation. It is ignored and flagged by an assertion.
- Redirect (highest priority, any state except S_BOOT):
  - pc <= {redirect_pc[63:2],2'b00}; FIFO flushed.
  - drop_cnt <= outstanding after this cycle's response and request events, plus 1 if a request is pending and not accepted this cycle.
  - Next state = S_DRAIN if that value >0, else S_RUN.
  - A pending unaccepted request keeps its old address until accepted. Its response is then dropped.
- Simultaneous events:
  - Redirect plus response in the same cycle: the response is dropped and excluded from drop_cnt.
  - Redirect plus id fire in the same cycle: the entry counts as consumed; the flush still empties the FIFO.
  - Redirect in S_DRAIN recomputes drop_cnt by the same rule.
- Decode interface:
  - id_valid = FIFO non-empty; id fire pops.
  - The FIFO is registered, so data pushed in cycle N is visible in N+1.
  - Push and pop in the same cycle are allowed when full or empty.
  - Minimum latency: request accepted at cycle 0, response at cycle 1, id_valid at cycle 2.
- Width/wrap: pc+4 wraps modulo 2^64. Counters are sized for FIFO_DEPTH and never exceed it.

Decomposition:
- Shared defines header: `ysyx_22050133_RESET_PC`, `ysyx_22050133_INST_NOP`, IFU state encodings.
- Sub-module ysyx_22050133_ifu_fifo: synchronous FIFO with flush, parameter DEPTH, data width 96. Instantiated for the instruction buffer.

Test Plan:
- Reset release, memory always ready, 1-cycle response:
  - Request addresses are 0x80000000, 0x80000004, ...
  - First id_valid 3 cycles after reset release with id_pc=0x80000000.
  - Steady state is 1 instruction per cycle.
- id_ready held low 10 cycles:
  - FIFO fills to 2; outstanding reaches 0; imem_req_valid drops.
  - On release, instructions resume in order with no PC skipped or duplicated.
- Redirect to 0x80000103 with 2 requests outstanding:
  - State goes to S_DRAIN with drop_cnt=2; both responses are discarded.
  - Next request address is 0x80000100; id_valid=0 until that response arrives.
- imem_req_ready low for 3 cycles while a redirect pulses:
  - imem_req_addr stays at its old value until accepted; that response is dropped.
  - The following request is at the redirect target.
- Redirect in the same cycle as a response and an id fire: FIFO empties, and drop_cnt excludes the same-cycle response.
- Async reset asserted mid-drain: all outputs go to reset values immediately; fetch restarts at RESET_PC.
